// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD types, constants and helpers for the BCD down counter.
package bcd_down_counter_pkg;

    localparam int unsigned BCD_WIDTH = 4;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    typedef logic [BCD_WIDTH-1:0] bcd_digit_t;

    // Non-BCD nibbles (A..F) saturate to 9 so the count never holds an illegal digit.
    function automatic bcd_digit_t clamp_bcd(input logic [BCD_WIDTH-1:0] value);
        return (value > BCD_MAX) ? BCD_MAX : bcd_digit_t'(value);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down counter: loads, decrements, and borrows to the next decade.
module bcd_down_digit
    import bcd_down_counter_pkg::*;
(
    input  logic       clk,
    input  logic       r,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       dec_in,
    input  logic       wrap_en,
    output bcd_digit_t digit,
    output logic       is_zero,
    output logic       borrow_out
);

    bcd_digit_t digit_q;

    // A zero digit under decrement rolls to 9 only when wrap_en allows it; otherwise it holds.
    always_ff @(posedge clk) begin
        if (!r) begin
            digit_q <= '0;
        end else if (load) begin
            digit_q <= clamp_bcd(load_digit);
        end else if (dec_in) begin
            if (digit_q == '0) begin
                digit_q <= wrap_en ? BCD_MAX : '0;
            end else begin
                digit_q <= digit_q - bcd_digit_t'(1);
            end
        end
    end

    assign digit      = digit_q;
    assign is_zero    = (digit_q == '0);
    assign borrow_out = dec_in & is_zero;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down counter with registered terminal-count and wrap pulses.
module bcd_down_counter
    import bcd_down_counter_pkg::*;
#(
    parameter int unsigned DIGITS       = 2,
    parameter bit          STOP_AT_ZERO = 1'b1
) (
    input  logic                          clk,
    input  logic                          r,
    input  logic                          en,
    input  logic                          load,
    input  logic [BCD_WIDTH*DIGITS-1:0]   load_val,
    output logic [BCD_WIDTH*DIGITS-1:0]   count,
    output logic                          zero,
    output logic                          tc,
    output logic                          wrap
);

    bcd_digit_t        digit_val [DIGITS];
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS:0]   dec_chain;
    logic              wrap_en;
    logic              upper_zero;
    logic              count_is_one;
    logic              tc_q;
    logic              wrap_q;

    assign dec_chain[0] = en;
    assign zero         = &digit_zero;
    // In stop mode a fully-zero count must not roll over, so every digit is told to hold at 0.
    assign wrap_en      = !(STOP_AT_ZERO && zero);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .r          (r),
            .load       (load),
            .load_digit (load_val[i*BCD_WIDTH +: BCD_WIDTH]),
            .dec_in     (dec_chain[i]),
            .wrap_en    (wrap_en),
            .digit      (digit_val[i]),
            .is_zero    (digit_zero[i]),
            .borrow_out (dec_chain[i+1])
        );
        assign count[i*BCD_WIDTH +: BCD_WIDTH] = digit_val[i];
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            upper_zero = upper_zero & digit_zero[i];
        end
    end

    assign count_is_one = upper_zero && (digit_val[0] == bcd_digit_t'(1));

    // A borrow out of the top digit means the whole count was zero while enabled.
    always_ff @(posedge clk) begin
        if (!r) begin
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else if (load) begin
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tc_q   <= en && count_is_one;
            wrap_q <= dec_chain[DIGITS] && !STOP_AT_ZERO;
        end
    end

    assign tc   = tc_q;
    assign wrap = wrap_q;

endmodule
